// File: rtl/mult_share_ctrl_pkg.sv
// Shared types and helpers for the shared-multiplier controller.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package mult_share_ctrl_pkg;

    localparam int NREQ_DEF  = 4;
    localparam int WIDTH_DEF = 8;
    localparam int MAX_NREQ  = 8;

    typedef enum logic [1:0] {
        ARB   = 2'b00,
        ISSUE = 2'b01,
        WAIT  = 2'b10,
        RESP  = 2'b11
    } state_t;

    // First set bit of req searching upward from ptr, wrapping at nreq.
    // Walks offsets from high to low so the smallest offset is the one left standing.
    // Returns 0 when no bit is set; callers qualify with their own any-request flag.
    function automatic int rr_pick(input logic [MAX_NREQ-1:0] req,
                                   input int                  ptr,
                                   input int                  nreq);
        logic [2:0] idx;
        rr_pick = 0;
        for (int i = MAX_NREQ - 1; i >= 0; i--) begin
            if (i < nreq) begin
                idx = 3'((ptr + i) % nreq);
                if (req[idx]) begin
                    rr_pick = int'(idx);
                end
            end
        end
    endfunction

endpackage

// File: rtl/mult_share_ctrl_rr_arbiter.sv
// Combinational round-robin winner search over NREQ level requests.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the pointer register lives in the parent.
//
// Ports: req (level requests), rr_ptr (search start), winner (index), any_req.
import mult_share_ctrl_pkg::*;

module rr_arbiter #(
    parameter  int NREQ = NREQ_DEF,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  rr_ptr,
    output logic [IDW-1:0]  winner,
    output logic            any_req
);

    logic [MAX_NREQ-1:0] req_ext;

    always_comb begin
        req_ext = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_ext[i] = req[i];
        end
        winner  = IDW'(rr_pick(req_ext, int'(rr_ptr), NREQ));
        any_req = |req;
    end

endmodule

// File: rtl/mult_share_ctrl.sv
// Shares one sequential repetitive-addition multiplier among NREQ requesters, round-robin.
// Latency: gnt at T, done at T+b+3 (T+3 for a zero operand; T+1 with MULT_ZERO_BYPASS_EN).
// Backpressure: requests are level-held until gnt; new requests wait while busy, none lost.
//
// Ports: clock/reset (async active-low); req, a_in, b_in from clients; gnt/done one-hot
// pulses and rsp_r product back to clients; busy status; mul_start/mul_a/mul_b to and
// mul_ready/mul_r from the multiplier.
// Optional macro MULT_ZERO_BYPASS_EN: zero operands complete without using the multiplier.
import mult_share_ctrl_pkg::*;

module mult_share_ctrl #(
    parameter  int NREQ  = NREQ_DEF,
    parameter  int WIDTH = WIDTH_DEF,
    localparam int IDW   = $clog2(NREQ)
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*WIDTH-1:0]   a_in,
    input  logic [NREQ*WIDTH-1:0]   b_in,
    output logic [NREQ-1:0]         gnt,
    output logic [NREQ-1:0]         done,
    output logic [2*WIDTH-1:0]      rsp_r,
    output logic                    busy,
    output logic                    mul_start,
    output logic [WIDTH-1:0]        mul_a,
    output logic [WIDTH-1:0]        mul_b,
    input  logic                    mul_ready,
    input  logic [2*WIDTH-1:0]      mul_r
);

    state_t           state;
    logic [IDW-1:0]   rr_ptr;
    logic [IDW-1:0]   id_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;

    logic [IDW-1:0]   win;
    logic             any_req;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req     (req),
        .rr_ptr  (rr_ptr),
        .winner  (win),
        .any_req (any_req)
    );

    assign sel_a = a_in[win*WIDTH +: WIDTH];
    assign sel_b = b_in[win*WIDTH +: WIDTH];

    // Operands are held from capture until the next capture; the multiplier
    // loads them a cycle after start, so they must not follow a_in/b_in.
    assign mul_a = a_q;
    assign mul_b = b_q;

`ifdef MULT_ZERO_BYPASS_EN
    logic sel_zero;
    assign sel_zero = (sel_a == '0) || (sel_b == '0);
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= ARB;
            rr_ptr    <= '0;
            id_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            rsp_r     <= '0;
            gnt       <= '0;
            done      <= '0;
            mul_start <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                ARB: begin
                    done <= '0;
                    if (any_req) begin
                        a_q   <= sel_a;
                        b_q   <= sel_b;
                        id_q  <= win;
                        // gnt and start are registered so they appear during ISSUE.
                        gnt   <= NREQ'(1) << win;
`ifdef MULT_ZERO_BYPASS_EN
                        mul_start <= !sel_zero;
`else
                        mul_start <= 1'b1;
`endif
                        busy  <= 1'b1;
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    gnt       <= '0;
                    mul_start <= 1'b0;
                    rr_ptr    <= (int'(id_q) == NREQ - 1) ? '0 : id_q + 1'b1;
`ifdef MULT_ZERO_BYPASS_EN
                    if ((a_q == '0) || (b_q == '0)) begin
                        rsp_r <= '0;
                        done  <= NREQ'(1) << id_q;
                        state <= RESP;
                    end else begin
                        state <= WAIT;
                    end
`else
                    state <= WAIT;
`endif
                end
                WAIT: begin
                    // Ready is low the cycle after start, so this never sees a stale ready.
                    if (mul_ready) begin
                        rsp_r <= mul_r;
                        done  <= NREQ'(1) << id_q;
                        state <= RESP;
                    end
                end
                RESP: begin
                    done  <= '0;
                    busy  <= 1'b0;
                    state <= ARB;
                end
                default: begin
                    state <= ARB;
                end
            endcase
        end
    end

endmodule

// File: doc/mult_share_ctrl.md
Name: mult_share_ctrl

Overview:
- Shares one sequential repetitive-addition multiplier between NREQ requesters using round-robin arbitration.
- Captures the winner's operands and holds them stable on the multiplier inputs. Pulses start, waits for the multiplier to return to ready, then returns the product with a per-requester done pulse.
- Sits between client blocks and the multiplier. Both blocks use the same clock and reset.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTH, 8, operand width; product is 2*WIDTH.

Ports:
- clock  in  1  system clock, positive edge.
- reset  in  1  asynchronous, active-low reset.
- req  in  NREQ  level request per requester; held until gnt.
- a_in  in  NREQ*WIDTH  operand A, slice i belongs to requester i; stable while req[i].
- b_in  in  NREQ*WIDTH  operand B, same slicing.
- gnt  out  NREQ  one-cycle pulse; operands of requester i were captured.
- done  out  NREQ  one-cycle pulse; rsp_r is valid for requester i.
- rsp_r  out  2*WIDTH  product; holds its value until the next done.
- busy  out  1  high whenever state != ARB.
- mul_start  out  1  start strobe to the multiplier.
- mul_a  out  WIDTH  multiplicand to the multiplier.
- mul_b  out  WIDTH  multiplier operand (iteration count).
- mul_ready  in  1  multiplier idle flag.
- mul_r  in  2*WIDTH  multiplier product.

Behaviour:
- Reset (async, reset=0): state=ARB, rr_ptr=0, a_q=b_q=0, id_q=0, rsp_r=0, and gnt, done, mul_start, busy all 0. This may occur mid-operation; the multiplier shares the reset, so the pair restarts clean and the in-flight request is dropped without a done.
- State machine: ARB -> ISSUE -> WAIT -> RESP -> ARB.
- ARB:
  - If any req bit is set, pick the first set bit searching from rr_ptr upward, wrapping at NREQ.
  - On the clock edge, latch a_q/b_q/id_q and go to ISSUE.
  - If no req bit is set, stay in ARB.
- ISSUE (1 cycle):
  - gnt[id_q]=1 and mul_start=1.
  - rr_ptr <= id_q+1, modulo NREQ.
  - Go to WAIT.
- WAIT:
  - mul_start=0.
  - The multiplier's ready is guaranteed low the cycle after start, so the first WAIT cycle never samples a stale ready.
  - When mul_ready=1: rsp_r <= mul_r, go to RESP.
- RESP (1 cycle): done[id_q]=1, then return to ARB.
- Operand hold: mul_a=a_q and mul_b=b_q at all times. The multiplier loads operands one cycle after start, so they must not change until the next ARB capture.
- Latency from the gnt cycle (T) to the done cycle:
  - If a==0 or b==0: done at T+3.
  - Otherwise: done at T+b+3.
- Throughput: the next gnt comes at the earliest 2 cycles after done.
- Request handling:
  - A requester must drop req the cycle after its gnt, or it re-arbitrates.
  - A req arriving during ISSUE/WAIT/RESP waits for ARB and is never lost.
  - Changes to req or operands outside ARB have no effect.
- Fairness: under continuous requests from all NREQ requesters, each is served exactly once per NREQ grants.
- Arithmetic: no truncation; rsp_r width is 2*WIDTH; 255*255 = 65025.

Optional Feature:
- Macro: MULT_ZERO_BYPASS_EN.
- With the macro defined:
  - In ISSUE, if a_q==0 or b_q==0, mul_start stays 0, rsp_r <= 0, and the next state is RESP (done at T+1). The multiplier is not used.
  - All other cases are unchanged.
- Without the macro: zero operands go through the multiplier as normal, with done at T+3.

Decomposition:
- Shared package:
  - State encoding: ARB=2'b00, ISSUE=2'b01, WAIT=2'b10, RESP=2'b11.
  - Default WIDTH/NREQ constants.
  - A round-robin priority function for next-winner search.
- One natural sub-module: rr_arbiter.
  - Parameter NREQ.
  - Inputs: req, rr_ptr. Outputs: winner index, any_req.
  - Purely combinational; the pointer register stays in mult_share_ctrl.

Test Plan:
- Single request: req[1] with a=3, b=5 -> gnt[1] at T, mul_start at T, done[1] at T+8, rsp_r=15, busy low again at T+9.
- Zero operand: req[0] with a=0, b=7 -> rsp_r=0 and done at T+3. With MULT_ZERO_BYPASS_EN: done at T+1 and mul_start never asserts.
- Round-robin: all 4 req held high, each with b=1 -> grant order 0,1,2,3,0; each requester gets exactly one done per 4 grants; rsp_r is correct for each id.
- Wrap and fairness: after serving requester 3, assert req[0] and req[2] together -> requester 0 is granted first; with rr_ptr=1 instead -> requester 2 is granted first.
- Max values: a=255, b=255 -> rsp_r=65025, done at T+258.
- Reset mid-WAIT: assert reset=0 for 2 cycles while b=10 is in flight -> all outputs 0 immediately, no done for that request, and a later request completes correctly.
